// File: rtl/mult_adder.sv
// Pipelined signed 8x8 dot-product unit: TREE_SIZE products summed through a
// three-stage registered adder tree, one 32-bit result per clock.
`ifndef MA_TREE_SIZE
`define MA_TREE_SIZE 16
`endif

module mult_adder #(
    parameter int TREE_SIZE = `MA_TREE_SIZE
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [8*TREE_SIZE-1:0]   in,
    input  logic [8*TREE_SIZE-1:0]   kernel,
    output logic signed [31:0]       out
);

    localparam int GROUPS = (TREE_SIZE + 3) / 4;

    logic signed [15:0] prod_d   [TREE_SIZE];
    logic signed [15:0] prod_q   [TREE_SIZE];
    logic signed [15:0] prod_pad [GROUPS*4];
    logic signed [31:0] part_d   [GROUPS];
    logic signed [31:0] part_q   [GROUPS];
    logic signed [31:0] sum_d;

    always_comb begin
        for (int i = 0; i < TREE_SIZE; i++) begin
            prod_d[i] = $signed({{8{in[8*i+7]}}, in[8*i +: 8]})
                      * $signed({{8{kernel[8*i+7]}}, kernel[8*i +: 8]});
        end
    end

    // Zero-padded copy so the last group of four never indexes past the products
    always_comb begin
        for (int i = 0; i < GROUPS*4; i++) begin
            prod_pad[i] = '0;
        end
        for (int i = 0; i < TREE_SIZE; i++) begin
            prod_pad[i] = prod_q[i];
        end
    end

    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            part_d[g] = 32'(prod_pad[4*g])   + 32'(prod_pad[4*g+1])
                      + 32'(prod_pad[4*g+2]) + 32'(prod_pad[4*g+3]);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int g = 0; g < GROUPS; g++) begin
            sum_d = sum_d + part_q[g];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TREE_SIZE; i++) begin
                prod_q[i] <= '0;
            end
            for (int g = 0; g < GROUPS; g++) begin
                part_q[g] <= '0;
            end
            out <= '0;
        end else begin
            for (int i = 0; i < TREE_SIZE; i++) begin
                prod_q[i] <= prod_d[i];
            end
            for (int g = 0; g < GROUPS; g++) begin
                part_q[g] <= part_d[g];
            end
            out <= sum_d;
        end
    end

endmodule

// File: tb/tb_mult_adder.sv
// Directed bench for mult_adder: streamed vector table with 3-edge latency,
// plus reset and mid-stream reset sequences.
module tb_mult_adder;

    localparam int TS = 16;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [8*TS-1:0]       in_vec;
    logic [8*TS-1:0]       kernel_vec;
    logic signed [31:0]    out;

    int checks = 0;
    int errors = 0;

    mult_adder #(.TREE_SIZE(TS)) dut (
        .clock  (clock),
        .reset  (reset),
        .in     (in_vec),
        .kernel (kernel_vec),
        .out    (out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [8*TS-1:0]    a;
        logic [8*TS-1:0]    k;
        logic signed [31:0] exp;
        string              name;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    function automatic logic [8*TS-1:0] fill(input logic [7:0] v);
        logic [8*TS-1:0] r;
        for (int i = 0; i < TS; i++) r[8*i +: 8] = v;
        return r;
    endfunction

    function automatic logic [8*TS-1:0] ramp();
        logic [8*TS-1:0] r;
        for (int i = 0; i < TS; i++) r[8*i +: 8] = 8'(i);
        return r;
    endfunction

    function automatic logic [8*TS-1:0] alternate(input logic [7:0] even_v, input logic [7:0] odd_v);
        logic [8*TS-1:0] r;
        for (int i = 0; i < TS; i++) r[8*i +: 8] = (i % 2 == 0) ? even_v : odd_v;
        return r;
    endfunction

    // Drive inputs on the falling edge, then wait until just after the next rising edge
    task automatic apply_stimulus(input logic rst, input logic [8*TS-1:0] a, input logic [8*TS-1:0] k);
        @(negedge clock);
        reset      = rst;
        in_vec     = a;
        kernel_vec = k;
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic signed [31:0] exp);
        checks++;
        if (out !== exp) begin
            errors++;
            $display("[TB] FAIL %s: out=%0d (0x%08h) expected=%0d (0x%08h)", name, out, out, exp, exp);
        end
    endtask

    initial begin
        vecs[0] = '{fill(8'h03), fill(8'h02), 32'sd96,      "const_3x2"};
        vecs[1] = '{fill(8'h02), fill(8'h02), 32'sd64,      "stream_2x2"};
        vecs[2] = '{fill(8'h03), fill(8'h02), 32'sd96,      "stream_3x2"};
        vecs[3] = '{fill(8'h80), fill(8'h80), 32'sd262144,  "neg128_sq"};
        vecs[4] = '{fill(8'h80), fill(8'h7F), 32'hFFFC0800, "neg128_x127"};
        vecs[5] = '{ramp(),      fill(8'h01), 32'sd120,     "ramp_x1"};
        vecs[6] = '{ramp(),      fill(8'hFF), -32'sd120,    "ramp_xm1"};
        vecs[7] = '{fill(8'h7F), fill(8'h7F), 32'sd258064,  "max_pos_sq"};
        vecs[8] = '{alternate(8'h7F, 8'h80), fill(8'h80), 32'sd1024, "alt_x_m128"};
        vecs[9] = '{fill(8'h00), fill(8'h00), 32'sd0,       "zeros"};

        reset      = 1'b1;
        in_vec     = fill(8'h55);
        kernel_vec = fill(8'h33);

        // Reset held two cycles with nonzero operands keeps out at zero
        apply_stimulus(1'b1, fill(8'h55), fill(8'h33));
        check_output("reset_hold_0", 32'sd0);
        apply_stimulus(1'b1, fill(8'h55), fill(8'h33));
        check_output("reset_hold_1", 32'sd0);
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(1'b0, fill(8'h00), fill(8'h00));
            check_output($sformatf("post_reset_zero_%0d", c), 32'sd0);
        end

        // Fill the pipeline, then reset with nonzero operands: nothing may leak out
        for (int c = 0; c < 3; c++) apply_stimulus(1'b0, fill(8'h7F), fill(8'h7F));
        apply_stimulus(1'b1, fill(8'h11), fill(8'h11));
        check_output("flush_reset", 32'sd0);
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(1'b0, fill(8'h00), fill(8'h00));
            check_output($sformatf("flush_cleared_%0d", c), 32'sd0);
        end

        // Back-to-back table stream: vector s appears just after edge s+2
        for (int c = 0; c < NV + 2; c++) begin
            if (c < NV) apply_stimulus(1'b0, vecs[c].a, vecs[c].k);
            else        apply_stimulus(1'b0, fill(8'h00), fill(8'h00));
            if (c >= 2) check_output(vecs[c-2].name, vecs[c-2].exp);
        end

        // Constant operands remain stable
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(1'b0, fill(8'h03), fill(8'h02));
            if (c >= 2) check_output($sformatf("const_stable_%0d", c), 32'sd96);
        end

        // Mid-stream reset discards in-flight 96s; 64s appear three edges later
        apply_stimulus(1'b0, fill(8'h03), fill(8'h02));
        apply_stimulus(1'b1, fill(8'h03), fill(8'h02));
        check_output("mid_reset", 32'sd0);
        apply_stimulus(1'b0, fill(8'h02), fill(8'h02));
        check_output("mid_after_1", 32'sd0);
        apply_stimulus(1'b0, fill(8'h02), fill(8'h02));
        check_output("mid_after_2", 32'sd0);
        apply_stimulus(1'b0, fill(8'h02), fill(8'h02));
        check_output("mid_resume", 32'sd64);
        apply_stimulus(1'b0, fill(8'h00), fill(8'h00));
        check_output("mid_resume_next", 32'sd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
